cdb_bus_controller: RTL and testbench

// - Central grant side of the common-data-bus handshake. Each combo's local

---
 rtl/cdb_pkg.sv | 27 ++
 rtl/rr_pick2.sv | 57 +++++
 rtl/cdb_bus_controller.sv | 157 +++++++++++++++
 tb/tb_cdb_bus_controller.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/cdb_pkg.sv
`default_nettype none
// ============================================================================
// Package     : cdb_pkg
// Description : Common-data-bus shared definitions. Used by the central
//               grant controller and by each combo's local arbiter when it
//               compares cdb[b].select against its own address.
// Revision    : 1.0  initial release
// ============================================================================
package cdb_pkg;

    // Number of common data buses driven by the controller.
    localparam int CDB_COUNT = 2;

    // Width of a select address and the "no owner" value on the bus.
    localparam int ADDR_W = 8;
    localparam logic [ADDR_W-1:0] IDLE_ADDR = 8'hFF;

    typedef logic [ADDR_W-1:0] cdb_addr_t;

    // Width needed to index n units. It is never zero, so a single-unit
    // build still gets a legal vector.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : cdb_pkg
`default_nettype wire

// File: rtl/rr_pick2.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick2
// Description : Combinational round-robin picker. It scans `eligible` upward
//               from `rr_ptr`, wrapping modulo NUM_UNITS, and returns the
//               first two hits in scan order.
// Ports       : eligible      in  NUM_UNITS  candidate request vector
//               rr_ptr        in  PTR_W      scan start index (< NUM_UNITS)
//               first_idx     out PTR_W      first hit in scan order
//               first_valid   out 1          first_idx is meaningful
//               second_idx    out PTR_W      second hit in scan order
//               second_valid  out 1          second_idx is meaningful
// Revision    : 1.0  initial release
// ============================================================================
module rr_pick2 #(
    parameter int NUM_UNITS = 8,
    parameter int PTR_W     = 3
) (
    input  logic [NUM_UNITS-1:0] eligible,
    input  logic [PTR_W-1:0]     rr_ptr,
    output logic [PTR_W-1:0]     first_idx,
    output logic                 first_valid,
    output logic [PTR_W-1:0]     second_idx,
    output logic                 second_valid
);

    int               w_sum;
    logic [PTR_W-1:0] w_scan;

    always_comb begin
        first_idx    = '0;
        first_valid  = 1'b0;
        second_idx   = '0;
        second_valid = 1'b0;
        w_sum        = 0;
        w_scan       = '0;
        for (int k = 0; k < NUM_UNITS; k++) begin
            // rr_ptr < NUM_UNITS, so a single subtraction is enough to wrap.
            w_sum = int'(rr_ptr) + k;
            if (w_sum >= NUM_UNITS) begin
                w_sum = w_sum - NUM_UNITS;
            end
            w_scan = PTR_W'(w_sum);
            if (eligible[w_scan]) begin
                if (!first_valid) begin
                    first_valid = 1'b1;
                    first_idx   = w_scan;
                end else if (!second_valid) begin
                    second_valid = 1'b1;
                    second_idx   = w_scan;
                end
            end
        end
    end

endmodule : rr_pick2
`default_nettype wire

// File: rtl/cdb_bus_controller.sv
`default_nettype none
// ============================================================================
// Module      : cdb_bus_controller
// Description : Central grant side of the common-data-bus handshake. It
//               samples every unit's get_bus and picks up to two winners per
//               cycle in round-robin order. It then drives the registered
//               owner address of cdb[0] and cdb[1].
// Ports       : clk           in  1             core clock
//               reset         in  1             async active-high reset
//               flush         in  1             drop pending arbitration
//               get_bus       in  NUM_UNITS     per-unit level request
//               bus_hold      in  2             bus b reserved next cycle
//               select        out 2 x ADDR_W    owner address of cdb[0..1]
//               select_valid  out 2             select[b] != IDLE_ADDR
//               granted       out NUM_UNITS     grant vector matching select
// Revision    : 1.0  initial release
// ============================================================================
module cdb_bus_controller #(
    parameter int                NUM_UNITS = 8,
    parameter int                ADDR_W    = cdb_pkg::ADDR_W,
    parameter logic [ADDR_W-1:0] IDLE_ADDR = cdb_pkg::IDLE_ADDR
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic [NUM_UNITS-1:0]       get_bus,
    input  logic [1:0]                 bus_hold,
    output logic [1:0][ADDR_W-1:0]     select,
    output logic [1:0]                 select_valid,
    output logic [NUM_UNITS-1:0]       granted
);

    import cdb_pkg::*;

    localparam int c_PTR_W = ptr_width(NUM_UNITS);
    localparam logic [c_PTR_W-1:0] c_LAST_UNIT = c_PTR_W'(NUM_UNITS - 1);

    logic [1:0][ADDR_W-1:0]      r_select;
    logic [1:0]                  r_select_valid;
    logic [NUM_UNITS-1:0]        r_granted;
    logic [c_PTR_W-1:0]          r_rr_ptr;

    logic [NUM_UNITS-1:0]        w_eligible;
    logic [c_PTR_W-1:0]          w_first_idx;
    logic                        w_first_valid;
    logic [c_PTR_W-1:0]          w_second_idx;
    logic                        w_second_valid;

    logic [1:0]                  w_bus_take;
    logic [1:0][c_PTR_W-1:0]     w_bus_idx;
    logic                        w_any_grant;
    logic [c_PTR_W-1:0]          w_last_idx;

    logic [1:0][ADDR_W-1:0]      w_select_nxt;
    logic [NUM_UNITS-1:0]        w_granted_nxt;
    logic [c_PTR_W-1:0]          w_rr_ptr_nxt;

    // A unit that owns a bus this cycle may still hold get_bus high, because
    // it only drops it after seeing its grant. It is masked so that it is
    // not granted twice.
    assign w_eligible = get_bus & ~r_granted;

    rr_pick2 #(
        .NUM_UNITS (NUM_UNITS),
        .PTR_W     (c_PTR_W)
    ) u_rr_pick2 (
        .eligible     (w_eligible),
        .rr_ptr       (r_rr_ptr),
        .first_idx    (w_first_idx),
        .first_valid  (w_first_valid),
        .second_idx   (w_second_idx),
        .second_valid (w_second_valid)
    );

    // Steer winners onto free buses. When one bus is held, the first winner
    // moves to the other bus and the second winner waits. The pointer then
    // advances past the last unit actually granted, so the waiting unit
    // comes first next time.
    always_comb begin
        w_bus_take    = 2'b00;
        w_bus_idx     = '0;
        w_any_grant   = 1'b0;
        w_last_idx    = '0;
        w_select_nxt  = {IDLE_ADDR, IDLE_ADDR};
        w_granted_nxt = '0;
        w_rr_ptr_nxt  = r_rr_ptr;

        if (!flush) begin
            case (bus_hold)
                2'b00: begin
                    w_bus_take   = {w_second_valid, w_first_valid};
                    w_bus_idx[0] = w_first_idx;
                    w_bus_idx[1] = w_second_idx;
                end
                2'b01: begin
                    w_bus_take   = {w_first_valid, 1'b0};
                    w_bus_idx[1] = w_first_idx;
                end
                2'b10: begin
                    w_bus_take   = {1'b0, w_first_valid};
                    w_bus_idx[0] = w_first_idx;
                end
                default: begin
                    w_bus_take = 2'b00;
                end
            endcase

            // A second winner is only ever taken onto bus 1 with both free.
            if (w_bus_take == 2'b11) begin
                w_any_grant = 1'b1;
                w_last_idx  = w_second_idx;
            end else if (w_bus_take != 2'b00) begin
                w_any_grant = 1'b1;
                w_last_idx  = w_first_idx;
            end

            for (int b = 0; b < 2; b++) begin
                if (w_bus_take[b]) begin
                    w_select_nxt[b]              = ADDR_W'(w_bus_idx[b]);
                    w_granted_nxt[w_bus_idx[b]]  = 1'b1;
                end
            end

            if (w_any_grant) begin
                w_rr_ptr_nxt = (w_last_idx == c_LAST_UNIT) ? '0
                                                           : w_last_idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_select       <= {IDLE_ADDR, IDLE_ADDR};
            r_select_valid <= 2'b00;
            r_granted      <= '0;
            r_rr_ptr       <= '0;
        end else begin
            r_select       <= w_select_nxt;
            r_select_valid <= w_bus_take;
            r_granted      <= w_granted_nxt;
            r_rr_ptr       <= w_rr_ptr_nxt;
        end
    end

    assign select       = r_select;
    assign select_valid = r_select_valid;
    assign granted      = r_granted;

    // Two buses must never name the same owner.
    a_distinct_owner : assert property (
        @(posedge clk) disable iff (reset)
        (r_select[0] != r_select[1]) ||
        ((r_select[0] == IDLE_ADDR) && (r_select[1] == IDLE_ADDR))
    );

endmodule : cdb_bus_controller
`default_nettype wire

// File: tb/tb_cdb_bus_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_cdb_bus_controller
// Description : Directed self-checking bench for cdb_bus_controller. It
//               covers an eight-unit instance and a three-unit instance,
//               the latter to exercise pointer wrap.
// Revision    : 1.0  initial release
// ============================================================================
module tb_cdb_bus_controller;

    logic             clk;
    logic             reset;
    logic             flush;
    logic [7:0]       get_bus;
    logic [1:0]       bus_hold;
    logic [1:0][7:0]  select;
    logic [1:0]       select_valid;
    logic [7:0]       granted;

    logic             flush3;
    logic [2:0]       get_bus3;
    logic [1:0]       hold3;
    logic [1:0][7:0]  select3;
    logic [1:0]       select_valid3;
    logic [2:0]       granted3;

    int               n_total;
    int               n_pass;
    logic [7:0]       prev_granted;

    cdb_bus_controller #(.NUM_UNITS(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush),
        .get_bus      (get_bus),
        .bus_hold     (bus_hold),
        .select       (select),
        .select_valid (select_valid),
        .granted      (granted)
    );

    cdb_bus_controller #(.NUM_UNITS(3)) dut3 (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush3),
        .get_bus      (get_bus3),
        .bus_hold     (hold3),
        .select       (select3),
        .select_valid (select_valid3),
        .granted      (granted3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Clock edge, then settle a little so outputs are sampled off the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_sel(input string tag, input logic [7:0] s0,
                              input logic [7:0] s1, input logic [7:0] g);
        check_eq({tag, ".sel0"},  select[0], s0);
        check_eq({tag, ".sel1"},  select[1], s1);
        check_eq({tag, ".valid"}, select_valid,
                 {30'd0, s1 != 8'hFF, s0 != 8'hFF});
        check_eq({tag, ".grant"}, granted, g);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        n_total  = 0;
        n_pass   = 0;
        reset    = 1'b1;
        flush    = 1'b0;
        get_bus  = 8'h00;
        bus_hold = 2'b00;
        flush3   = 1'b0;
        get_bus3 = 3'b000;
        hold3    = 2'b00;

        // Reset state
        tick();
        expect_sel("reset", 8'hFF, 8'hFF, 8'h00);
        check_eq("reset.ptr", dut.r_rr_ptr, 0);
        reset = 1'b0;

        // Two requesters: grant, masked cycle, grant again
        get_bus = 8'b0000_0110;
        tick();
        expect_sel("pair1", 8'd1, 8'd2, 8'h06);
        check_eq("pair1.ptr", dut.r_rr_ptr, 3);
        tick();
        expect_sel("pair_mask", 8'hFF, 8'hFF, 8'h00);
        check_eq("pair_mask.ptr", dut.r_rr_ptr, 3);
        tick();
        expect_sel("pair2", 8'd1, 8'd2, 8'h06);

        // Get select=3/5, then reset asynchronously between edges
        get_bus = 8'h00;
        tick();
        get_bus = 8'b0010_1000;
        tick();
        expect_sel("pre_rst", 8'd3, 8'd5, 8'h28);
        reset = 1'b1;
        #2;
        expect_sel("async_rst", 8'hFF, 8'hFF, 8'h00);
        check_eq("async_rst.ptr", dut.r_rr_ptr, 0);
        get_bus = 8'h00;
        tick();
        reset = 1'b0;

        // All units requesting: pairs rotate, no unit granted back-to-back
        get_bus      = 8'hFF;
        prev_granted = 8'h00;
        tick();
        expect_sel("all0", 8'd0, 8'd1, 8'h03);
        prev_granted = granted;
        tick();
        expect_sel("all1", 8'd2, 8'd3, 8'h0C);
        check_eq("all1.norepeat", granted & prev_granted, 0);
        prev_granted = granted;
        tick();
        expect_sel("all2", 8'd4, 8'd5, 8'h30);
        check_eq("all2.norepeat", granted & prev_granted, 0);
        prev_granted = granted;
        tick();
        expect_sel("all3", 8'd6, 8'd7, 8'hC0);
        check_eq("all3.norepeat", granted & prev_granted, 0);
        prev_granted = granted;
        tick();
        expect_sel("all4", 8'd0, 8'd1, 8'h03);
        check_eq("all4.norepeat", granted & prev_granted, 0);

        // Single requester: served on cdb[0] every second cycle
        get_bus = 8'h00;
        tick();
        do_reset();
        get_bus = 8'h01;
        tick();
        expect_sel("single0", 8'd0, 8'hFF, 8'h01);
        tick();
        expect_sel("single1", 8'hFF, 8'hFF, 8'h00);
        tick();
        expect_sel("single2", 8'd0, 8'hFF, 8'h01);

        // bus_hold steering: held bus 0 pushes the winner onto bus 1
        get_bus = 8'h00;
        tick();
        do_reset();
        get_bus  = 8'b0001_0001;
        bus_hold = 2'b01;
        tick();
        expect_sel("hold0", 8'hFF, 8'd0, 8'h01);
        check_eq("hold0.ptr", dut.r_rr_ptr, 1);
        bus_hold = 2'b00;
        tick();
        expect_sel("hold_rel", 8'd4, 8'hFF, 8'h10);
        check_eq("hold_rel.ptr", dut.r_rr_ptr, 5);
        bus_hold = 2'b11;
        tick();
        expect_sel("hold_both", 8'hFF, 8'hFF, 8'h00);
        check_eq("hold_both.ptr", dut.r_rr_ptr, 5);

        // Flush overrides requests; pointer is kept
        bus_hold = 2'b00;
        get_bus  = 8'h00;
        tick();
        get_bus = 8'h0C;
        flush   = 1'b1;
        tick();
        expect_sel("flush", 8'hFF, 8'hFF, 8'h00);
        check_eq("flush.ptr", dut.r_rr_ptr, 5);
        flush = 1'b0;
        tick();
        expect_sel("post_flush", 8'd2, 8'd3, 8'h0C);
        check_eq("post_flush.ptr", dut.r_rr_ptr, 4);
        get_bus = 8'h00;

        // Three-unit instance: move the pointer to 2, then wrap it to 0
        get_bus3 = 3'b010;
        tick();
        check_eq("n3a.sel0", select3[0], 8'd1);
        check_eq("n3a.sel1", select3[1], 8'hFF);
        check_eq("n3a.ptr", dut3.r_rr_ptr, 2);
        get_bus3 = 3'b000;
        tick();
        get_bus3 = 3'b100;
        tick();
        check_eq("n3b.sel0", select3[0], 8'd2);
        check_eq("n3b.sel1", select3[1], 8'hFF);
        check_eq("n3b.valid", select_valid3, 2'b01);
        check_eq("n3b.grant", granted3, 3'b100);
        check_eq("n3b.ptr", dut3.r_rr_ptr, 0);
        get_bus3 = 3'b000;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_cdb_bus_controller
`default_nettype wire
